mips_memsys: RTL and testbench
==============================

MIPS_MEMSYS -- requirements
Module: mips_memsys

Interface
REQ-001 SHALL have parameter IMEM_WORDS, default 64, instruction memory depth in 32-bit words (power of 2).
REQ-002 SHALL have parameter DMEM_WORDS, default 64, data memory depth in 32-bit words (power of 2).
REQ-003 SHALL have one clock and a synchronous, active-high reset.
REQ-004 SHALL provide ports (name  direction  width  meaning):
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous active-high reset
- load_valid  in  1  loader byte valid
- load_byte  in  8  loader program byte
- load_last  in  1  final byte of program, qualified by load_valid
- load_ready  out  1  loader accepts byte this cycle
- cpu_reset  out  1  hold-in-reset to processor
- loaded_words  out  16  count of instruction words written
- PCF  in  32  fetch address
- InstrF  out  32  instruction at PCF
- StallD  in  1  hold decode register
- FlushD  in  1  clear decode register
- InstrD  out  32  registered decode-stage instruction
- MemWriteM  in  1  data write strobe
- AluOutM  in  32  data byte address
- WriteDataM  in  32  data write value
- ReadDataM  out  32  data read value
- misalign_err  out  1  sticky misaligned-access flag

Function
REQ-005 SHALL implement a two-state FSM: LOAD, RUN.
REQ-006 SHALL drive load_ready=1 in LOAD, 0 in RUN.
REQ-007 SHALL drive cpu_reset=1 whenever reset=1 or state=LOAD, else 0.
REQ-008 SHALL, in LOAD, accept load_byte on each cycle with load_valid=1. Bytes assemble big-endian: first byte -> bits [31:24].
REQ-009 SHALL, on acceptance of the 4th byte of a word, write the word to imem[wptr] that cycle, increment wptr and loaded_words, and reset the byte counter.
REQ-010 SHALL, when load_last=1 arrives on byte 1-3 of a word, zero-pad the remaining low bytes, write the word, increment counters, and transition to RUN next cycle.
REQ-011 SHALL, when load_last=1 arrives on the 4th byte, write normally and transition to RUN.
REQ-012 SHALL, when the word written is at wptr=IMEM_WORDS-1, transition to RUN regardless of load_last. No wrap; no further writes.
REQ-013 SHALL ignore load_valid in RUN. RUN is left only by reset.
REQ-014 SHALL drive InstrF = imem[PCF[log2(IMEM_WORDS)+1:2]] combinationally. Upper PCF bits are ignored, so addresses alias.
REQ-015 SHALL update InstrD on each rising edge with priority: reset -> 0; else StallD=1 -> hold; else FlushD=1 -> 0; else InstrF. StallD and FlushD together means hold.
REQ-016 SHALL clear InstrD to 0 on every cycle in which cpu_reset=1.
REQ-017 SHALL drive ReadDataM = dmem[AluOutM[log2(DMEM_WORDS)+1:2]] combinationally at all times.
REQ-018 SHALL write WriteDataM to the addressed dmem word on the rising edge when state=RUN, MemWriteM=1 and AluOutM[1:0]=00.
REQ-019 SHALL suppress the write and set misalign_err=1 when state=RUN, MemWriteM=1 and AluOutM[1:0]!=00. The flag stays set until reset.
REQ-020 SHALL ignore MemWriteM in LOAD.
REQ-021 SHALL saturate loaded_words at IMEM_WORDS. No overflow is possible.

Reset
REQ-022 SHALL, on reset=1 at a clock edge, set state=LOAD, wptr=0, byte counter=0, assembly register=0, loaded_words=0, InstrD=0, misalign_err=0.
REQ-023 SHALL NOT clear imem or dmem contents on reset. Reset during LOAD discards any partial word; a later load overwrites from word 0.
REQ-024 SHALL give reset priority over all simultaneous events, including load_last and MemWriteM.

Verification
REQ-025 Load bytes 20,08,00,05,AC,02,00,54 with load_last on the 8th byte -> imem[0]=20080005, imem[1]=AC020054, loaded_words=2, cpu_reset falls one cycle after the last byte.
REQ-026 Load 5 bytes 11,22,33,44,55 with load_last on the 5th -> imem[1]=55000000, loaded_words=2, state=RUN.
REQ-027 RUN, PCF=00000004 -> InstrF=AC020054 same cycle; next edge with StallD=0, FlushD=0 -> InstrD=AC020054; StallD=1 and FlushD=1 -> InstrD holds; FlushD=1 only -> InstrD=0.
REQ-028 RUN, MemWriteM=1, AluOutM=00000054, WriteDataM=00000007 -> ReadDataM=00000007 at address 54 next cycle. Then AluOutM=00000056 with a write -> memory unchanged, misalign_err=1 until reset.
REQ-029 Stream 256 bytes without load_last -> after word 63, state=RUN, loaded_words=64, load_ready=0, further bytes ignored.
REQ-030 Assert reset after 6 bytes of a load -> loaded_words=0, cpu_reset=1, imem[0] retains its first-written word. Reload starts at byte 0 of word 0.

Source files
------------

// File: rtl/mips_memsys.sv
// Instruction/data memory subsystem for a small MIPS core: a byte-serial program
// loader that holds the core in reset, a fetch/decode instruction register and a word data memory.
module mips_memsys #(
  parameter int IMEM_WORDS = 64,
  parameter int DMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_valid,
  input  logic [7:0]  load_byte,
  input  logic        load_last,
  output logic        load_ready,
  output logic        cpu_reset,
  output logic [15:0] loaded_words,
  input  logic [31:0] PCF,
  output logic [31:0] InstrF,
  input  logic        StallD,
  input  logic        FlushD,
  output logic [31:0] InstrD,
  input  logic        MemWriteM,
  input  logic [31:0] AluOutM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        misalign_err
);

  localparam int IA_W = $clog2(IMEM_WORDS);
  localparam int DA_W = $clog2(DMEM_WORDS);

  typedef enum logic {S_LOAD, S_RUN} state_t;

  state_t            state_q, state_d;
  logic [IA_W-1:0]   wptr_q, wptr_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [31:0]       asm_q, asm_d;
  logic [15:0]       lw_q, lw_d;
  logic [31:0]       instrd_q, instrd_d;
  logic              mis_q, mis_d;

  logic [31:0]       imem [IMEM_WORDS];
  logic [31:0]       dmem [DMEM_WORDS];

  logic              imem_we;
  logic              dmem_we;
  logic [31:0]       asm_next;
  logic [IA_W-1:0]   iaddr;
  logic [DA_W-1:0]   daddr;
  logic              unused_addr_bits;

  // Word-index the memories; upper address bits are dropped so addresses alias.
  assign iaddr            = PCF[IA_W+1:2];
  assign daddr            = AluOutM[DA_W+1:2];
  assign unused_addr_bits = ^{PCF[31:IA_W+2], PCF[1:0], AluOutM[31:DA_W+2]};

  assign InstrF       = imem[iaddr];
  assign ReadDataM    = dmem[daddr];
  assign load_ready   = (state_q == S_LOAD);
  assign cpu_reset    = reset | (state_q == S_LOAD);
  assign loaded_words = lw_q;
  assign InstrD       = instrd_q;
  assign misalign_err = mis_q;

  // Big-endian placement: byte 0 of a word lands in [31:24]; unfilled bytes stay zero.
  assign asm_next = asm_q | ({load_byte, 24'h000000} >> {bcnt_q, 3'b000});

  always_comb begin
    state_d  = state_q;
    wptr_d   = wptr_q;
    bcnt_d   = bcnt_q;
    asm_d    = asm_q;
    lw_d     = lw_q;
    mis_d    = mis_q;
    imem_we  = 1'b0;
    dmem_we  = 1'b0;
    instrd_d = instrd_q;

    if (cpu_reset) begin
      instrd_d = 32'h0;
    end else if (StallD) begin
      instrd_d = instrd_q;
    end else if (FlushD) begin
      instrd_d = 32'h0;
    end else begin
      instrd_d = InstrF;
    end

    if (!reset) begin
      if (state_q == S_LOAD) begin
        if (load_valid) begin
          if ((bcnt_q == 2'd3) || load_last) begin
            imem_we = 1'b1;
            wptr_d  = wptr_q + IA_W'(1);
            bcnt_d  = 2'd0;
            asm_d   = 32'h0;
            if (lw_q < 16'(IMEM_WORDS)) lw_d = lw_q + 16'd1;
            if (load_last || (wptr_q == IA_W'(IMEM_WORDS - 1))) state_d = S_RUN;
          end else begin
            bcnt_d = bcnt_q + 2'd1;
            asm_d  = asm_next;
          end
        end
      end else if (MemWriteM) begin
        if (AluOutM[1:0] == 2'b00) dmem_we = 1'b1;
        else                       mis_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_LOAD;
      wptr_q   <= '0;
      bcnt_q   <= 2'd0;
      asm_q    <= 32'h0;
      lw_q     <= 16'h0;
      instrd_q <= 32'h0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wptr_q   <= wptr_d;
      bcnt_q   <= bcnt_d;
      asm_q    <= asm_d;
      lw_q     <= lw_d;
      instrd_q <= instrd_d;
      mis_q    <= mis_d;
    end
  end

  // Memory contents survive reset; the enables already exclude the reset cycle.
  always_ff @(posedge clk) begin
    if (imem_we) imem[wptr_q] <= asm_next;
    if (dmem_we) dmem[daddr]  <= WriteDataM;
  end

endmodule

// File: tb/tb_mips_memsys.sv
// Bench for mips_memsys: a byte-queue reference model checked every cycle, plus
// directed loader, fetch/decode and data-memory scenarios with literal expectations.
module tb_mips_memsys;

  localparam int IW = 64;
  localparam int DW = 64;
  localparam int IA = $clog2(IW);
  localparam int DA = $clog2(DW);

  logic        clk = 1'b0;
  logic        reset;
  logic        load_valid;
  logic [7:0]  load_byte;
  logic        load_last;
  logic        load_ready;
  logic        cpu_reset;
  logic [15:0] loaded_words;
  logic [31:0] PCF;
  logic [31:0] InstrF;
  logic        StallD;
  logic        FlushD;
  logic [31:0] InstrD;
  logic        MemWriteM;
  logic [31:0] AluOutM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;
  logic        misalign_err;

  int checks = 0;
  int failures = 0;

  mips_memsys #(.IMEM_WORDS(IW), .DMEM_WORDS(DW)) dut (
    .clk(clk), .reset(reset),
    .load_valid(load_valid), .load_byte(load_byte), .load_last(load_last),
    .load_ready(load_ready), .cpu_reset(cpu_reset), .loaded_words(loaded_words),
    .PCF(PCF), .InstrF(InstrF), .StallD(StallD), .FlushD(FlushD), .InstrD(InstrD),
    .MemWriteM(MemWriteM), .AluOutM(AluOutM), .WriteDataM(WriteDataM),
    .ReadDataM(ReadDataM), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the program is the byte stream since the last reset;
  // word k is bytes 4k..4k+3, zero-padded if the stream ended early.
  logic [31:0] m_imem [IW];
  bit          m_ik   [IW];
  logic [31:0] m_dmem [DW];
  bit          m_dk   [DW];
  bit          m_init = 0;
  bit          m_run;
  bit          m_mis;
  int          m_words;
  logic [31:0] m_instrd;
  bit          m_idk;
  logic [7:0]  q[$];

  always @(posedge clk) begin
    int pi, di, n, k;
    logic [31:0] w;
    if (reset) begin
      m_init = 1; m_run = 0; m_mis = 0; m_words = 0;
      m_instrd = 32'h0; m_idk = 1; q.delete();
    end else if (m_init) begin
      pi = int'(PCF[IA+1:2]);
      di = int'(AluOutM[DA+1:2]);
      if (!m_run) begin
        m_instrd = 32'h0; m_idk = 1;
      end else if (!StallD) begin
        if (FlushD) begin m_instrd = 32'h0; m_idk = 1; end
        else begin m_instrd = m_imem[pi]; m_idk = m_ik[pi]; end
      end
      if (m_run && MemWriteM) begin
        if (AluOutM[1:0] == 2'b00) begin m_dmem[di] = WriteDataM; m_dk[di] = 1; end
        else m_mis = 1;
      end
      if (!m_run && load_valid) begin
        q.push_back(load_byte);
        n = q.size();
        if ((n % 4 == 0) || load_last) begin
          k = (n - 1) / 4;
          w = 32'h0;
          for (int i = 0; i < 4; i++)
            if (4 * k + i < n) w = w | (32'(q[4 * k + i]) << (24 - 8 * i));
          m_imem[k] = w; m_ik[k] = 1;
          m_words = k + 1;
          if (load_last || k == IW - 1) m_run = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    int pi, di;
    if (m_init) begin
      pi = int'(PCF[IA+1:2]);
      di = int'(AluOutM[DA+1:2]);
      chk("load_ready", {31'h0, load_ready}, {31'h0, !m_run});
      chk("cpu_reset", {31'h0, cpu_reset}, {31'h0, reset || !m_run});
      chk("loaded_words", {16'h0, loaded_words}, 32'(m_words));
      chk("misalign_err", {31'h0, misalign_err}, {31'h0, m_mis});
      if (m_idk) chk("InstrD", InstrD, m_instrd);
      if (m_ik[pi]) chk("InstrF", InstrF, m_imem[pi]);
      if (m_dk[di]) chk("ReadDataM", ReadDataM, m_dmem[di]);
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [7:0] b, input logic last);
    load_valid = 1'b1; load_byte = b; load_last = last;
    tick();
    load_valid = 1'b0; load_last = 1'b0;
  endtask

  initial begin
    reset = 1'b1; load_valid = 1'b0; load_byte = 8'h0; load_last = 1'b0;
    PCF = 32'h0; StallD = 1'b0; FlushD = 1'b0;
    MemWriteM = 1'b0; AluOutM = 32'h0; WriteDataM = 32'h0;
    tick(); tick();
    chk("reset_loaded", {16'h0, loaded_words}, 32'h0);
    chk("reset_cpu_reset", {31'h0, cpu_reset}, 32'h1);
    reset = 1'b0;

    // Two-word program, last byte on a word boundary
    send(8'h20, 0); send(8'h08, 0); send(8'h00, 0); send(8'h05, 0);
    send(8'hAC, 0); send(8'h02, 0); send(8'h00, 0);
    chk("cpu_reset_before_last", {31'h0, cpu_reset}, 32'h1);
    send(8'h54, 1);
    chk("cpu_reset_after_last", {31'h0, cpu_reset}, 32'h0);
    chk("loaded_two", {16'h0, loaded_words}, 32'h2);
    chk("model_imem0", m_imem[0], 32'h20080005);
    chk("model_imem1", m_imem[1], 32'hAC020054);
    PCF = 32'h0; #1 chk("InstrF_0", InstrF, 32'h20080005);
    PCF = 32'h4; #1 chk("InstrF_4", InstrF, 32'hAC020054);

    // Decode register: load, stall+flush hold, flush clear, reload
    tick(); chk("InstrD_load", InstrD, 32'hAC020054);
    StallD = 1'b1; FlushD = 1'b1; PCF = 32'h0;
    tick(); chk("InstrD_stall_flush", InstrD, 32'hAC020054);
    StallD = 1'b0;
    tick(); chk("InstrD_flush", InstrD, 32'h0);
    FlushD = 1'b0;
    tick(); chk("InstrD_reload", InstrD, 32'h20080005);

    // Data memory: aligned write, misaligned write suppressed, aliasing
    MemWriteM = 1'b1; AluOutM = 32'h54; WriteDataM = 32'h7;
    tick(); MemWriteM = 1'b0;
    #1 chk("dmem_54", ReadDataM, 32'h7);
    chk("mis_clear", {31'h0, misalign_err}, 32'h0);
    MemWriteM = 1'b1; AluOutM = 32'h56; WriteDataM = 32'hDEADBEEF;
    tick(); MemWriteM = 1'b0;
    #1 chk("mis_set", {31'h0, misalign_err}, 32'h1);
    chk("dmem_unchanged", ReadDataM, 32'h7);
    MemWriteM = 1'b1; AluOutM = 32'h100; WriteDataM = 32'h12345678;
    tick(); MemWriteM = 1'b0; AluOutM = 32'h0;
    #1 chk("dmem_alias", ReadDataM, 32'h12345678);
    tick(); tick();
    chk("mis_sticky", {31'h0, misalign_err}, 32'h1);
    send(8'hEE, 1);
    chk("run_ignores_load", {16'h0, loaded_words}, 32'h2);

    // Reset beats a simultaneous write and load byte
    reset = 1'b1; MemWriteM = 1'b1; AluOutM = 32'h54; WriteDataM = 32'h55555555;
    load_valid = 1'b1; load_byte = 8'h77; load_last = 1'b1;
    tick();
    reset = 1'b0; MemWriteM = 1'b0; load_valid = 1'b0; load_last = 1'b0;
    #1 chk("rst_dmem_kept", ReadDataM, 32'h7);
    chk("rst_mis", {31'h0, misalign_err}, 32'h0);
    chk("rst_loaded", {16'h0, loaded_words}, 32'h0);
    chk("rst_load_ready", {31'h0, load_ready}, 32'h1);

    // Partial final word, with write strobes ignored during LOAD
    MemWriteM = 1'b1; AluOutM = 32'h0; WriteDataM = 32'hAAAAAAAA;
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
    send(8'h55, 1);
    MemWriteM = 1'b0;
    chk("partial_loaded", {16'h0, loaded_words}, 32'h2);
    chk("partial_run", {31'h0, load_ready}, 32'h0);
    PCF = 32'h4; #1 chk("partial_word1", InstrF, 32'h55000000);
    PCF = 32'h0; #1 chk("partial_word0", InstrF, 32'h11223344);
    chk("load_ignores_write", ReadDataM, 32'h12345678);

    // Reset mid-load keeps imem, reload restarts at word 0
    reset = 1'b1; tick(); reset = 1'b0;
    send(8'hA1, 0); send(8'hA2, 0); send(8'hA3, 0);
    send(8'hA4, 0); send(8'hA5, 0); send(8'hA6, 0);
    chk("midload_loaded", {16'h0, loaded_words}, 32'h1);
    reset = 1'b1; tick(); reset = 1'b0;
    #1 chk("midrst_loaded", {16'h0, loaded_words}, 32'h0);
    chk("midrst_cpu_reset", {31'h0, cpu_reset}, 32'h1);
    PCF = 32'h0; #1 chk("midrst_imem0", InstrF, 32'hA1A2A3A4);
    send(8'hB0, 0); send(8'hB1, 0); send(8'hB2, 0); send(8'hB3, 1);
    chk("reload_loaded", {16'h0, loaded_words}, 32'h1);
    chk("reload_imem0", InstrF, 32'hB0B1B2B3);

    // Fill the whole instruction memory without load_last
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < 256; i++) send(8'(i), 0);
    chk("full_loaded", {16'h0, loaded_words}, 32'd64);
    chk("full_ready", {31'h0, load_ready}, 32'h0);
    for (int i = 0; i < 4; i++) send(8'hF0, 0);
    chk("full_saturated", {16'h0, loaded_words}, 32'd64);
    PCF = 32'hFC;  #1 chk("full_word63", InstrF, 32'hFCFDFEFF);
    PCF = 32'h100; #1 chk("full_word0_alias", InstrF, 32'h00010203);
    chk("model_word63", m_imem[63], 32'hFCFDFEFF);

    tick(); tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
